// File: rtl/rll_key_loader.sv
// rll_key_loader: serial key intake with XOR-fold checksum verification.
// The parallel key bus only changes on a verified commit; repeated checksum
// failures force the bus to DEFAULT_KEY until reset.
module rll_key_loader #(
  parameter int                   KEY_WIDTH   = 32,
  parameter logic [KEY_WIDTH-1:0] DEFAULT_KEY = '0,
  parameter int                   MAX_FAIL    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sdi,
  input  logic                 sdi_valid,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_ready,
  output logic                 busy,
  output logic                 err,
  output logic                 locked_out
);

  localparam int CW = $clog2(KEY_WIDTH + 8);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(KEY_WIDTH + 7);
  localparam logic [CW-1:0] KEY_BITS  = CW'(KEY_WIDTH);
  localparam logic [FW-1:0] FAIL_LIM  = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_DONE,
    S_LOCKOUT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CW-1:0]          r_cnt;
  logic [KEY_WIDTH-1:0]   r_shadow;
  logic [7:0]             r_csum;
  logic [FW-1:0]          r_fail;
  logic [FW-1:0]          w_fail_inc;
  logic [7:0]             w_calc;
  logic                   w_match;
  logic                   w_start_ok;

  logic [KEY_WIDTH-1:0]   w_key_out_n;
  logic                   w_key_ready_n;
  logic                   w_busy_n;
  logic                   w_err_n;
  logic                   w_locked_n;
  logic [FW-1:0]          w_fail_n;

  // XOR-fold of the received key bytes against the received checksum
  always_comb begin
    w_calc = '0;
    for (int unsigned b = 0; b < KEY_WIDTH / 8; b++) begin
      w_calc = w_calc ^ r_shadow[b*8 +: 8];
    end
    w_match    = (w_calc == r_csum);
    w_fail_inc = (r_fail == FAIL_LIM) ? r_fail : r_fail + 1'b1;
    w_start_ok = start && (r_state == S_IDLE || r_state == S_SHIFT ||
                           r_state == S_DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_SHIFT;
      S_SHIFT: begin
        if (start)                                w_state_next = S_SHIFT;
        else if (sdi_valid && r_cnt == LAST_BIT)  w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_match)                    w_state_next = S_DONE;
        else if (w_fail_inc == FAIL_LIM) w_state_next = S_LOCKOUT;
        else if (key_ready)             w_state_next = S_DONE;
        else                            w_state_next = S_IDLE;
      end
      S_DONE:    if (start) w_state_next = S_SHIFT;
      S_LOCKOUT: w_state_next = S_LOCKOUT;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the fail counter
  always_comb begin
    w_key_out_n   = key_out;
    w_key_ready_n = key_ready;
    w_busy_n      = (w_state_next == S_SHIFT) || (w_state_next == S_CHECK);
    w_err_n       = 1'b0;
    w_locked_n    = (w_state_next == S_LOCKOUT);
    w_fail_n      = r_fail;
    if (r_state == S_CHECK) begin
      if (w_match) begin
        w_key_out_n   = r_shadow;
        w_key_ready_n = 1'b1;
        w_fail_n      = '0;
      end else begin
        w_err_n  = 1'b1;
        w_fail_n = w_fail_inc;
        if (w_state_next == S_LOCKOUT) begin
          w_key_out_n   = DEFAULT_KEY;
          w_key_ready_n = 1'b0;
        end
      end
    end
  end

  // Bit counter and shadow/checksum shift registers; start wins over a bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_csum   <= '0;
    end else if (w_start_ok) begin
      r_cnt <= '0;
    end else if (r_state == S_SHIFT && sdi_valid) begin
      if (r_cnt < KEY_BITS) r_shadow <= {sdi, r_shadow[KEY_WIDTH-1:1]};
      else                  r_csum   <= {sdi, r_csum[7:1]};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Output and fail-counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_out    <= DEFAULT_KEY;
      key_ready  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      locked_out <= 1'b0;
      r_fail     <= '0;
    end else begin
      key_out    <= w_key_out_n;
      key_ready  <= w_key_ready_n;
      busy       <= w_busy_n;
      err        <= w_err_n;
      locked_out <= w_locked_n;
      r_fail     <= w_fail_n;
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Scoreboard bench for rll_key_loader: the stimulus pushes the expected
// output event for each frame; a monitor pops on every output event.
module tb_rll_key_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sdi = 1'b0;
  logic        sdi_valid = 1'b0;
  logic [31:0] key_out;
  logic        key_ready, busy, err, locked_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b1;

  typedef struct {
    logic [31:0] key;
    logic        ready;
    logic        err;
    logic        locked;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  rll_key_loader #(
    .KEY_WIDTH  (32),
    .DEFAULT_KEY(32'h0000_0000),
    .MAX_FAIL   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sdi       (sdi),
    .sdi_valid (sdi_valid),
    .key_out   (key_out),
    .key_ready (key_ready),
    .busy      (busy),
    .err       (err),
    .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any err pulse or change of key_out/key_ready/locked_out is an event
  initial begin
    logic [31:0] pk;
    logic        pr, pl;
    exp_t        e;
    pk = '0; pr = 1'b0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        pk = key_out; pr = key_ready; pl = locked_out;
      end else if (err === 1'b1 || key_out !== pk || key_ready !== pr || locked_out !== pl) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: key=%h ready=%b err=%b locked=%b cycle %0d, expected no change",
                   key_out, key_ready, err, locked_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("ev_key",    key_out,        e.key);
          chk("ev_ready",  32'(key_ready), 32'(e.ready));
          chk("ev_err",    32'(err),       32'(e.err));
          chk("ev_locked", 32'(locked_out), 32'(e.locked));
          chk("ev_cycle",  32'(cyc),       32'(e.cyc));
        end
        pk = key_out; pr = key_ready; pl = locked_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; sdi_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_key"},    key_out,          32'h0);
    chk({tag, "_ready"},  32'(key_ready),   32'h0);
    chk({tag, "_busy"},   32'(busy),        32'h0);
    chk({tag, "_err"},    32'(err),         32'h0);
    chk({tag, "_locked"}, 32'(locked_out),  32'h0);
  endtask

  task automatic send_start(input logic exp_busy);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(exp_busy));
  endtask

  task automatic send_bits(input logic [39:0] frame, input int lo, input int hi,
                           input bit gaps, output int last_e);
    last_e = cyc;
    for (int i = lo; i < hi; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      sdi = frame[i];
      sdi_valid = 1'b1;
      tick();
      last_e = cyc;
      sdi_valid = 1'b0;
    end
  endtask

  task automatic push(input logic [31:0] k, input logic r, input logic e,
                      input logic l, input int c);
    exp_t x;
    x.key = k; x.ready = r; x.err = e; x.locked = l; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d events pending, required 0", sb.size());
      sb.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    int e;
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    do_reset();
    check_reset_vals("reset");

    // Good frame, continuous sdi_valid
    send_start(1'b1);
    send_bits({8'h7B, 32'hA5C3_0F12}, 0, 40, 1'b0, e);
    chk("busy_in_check", 32'(busy), 32'h1);
    push(32'hA5C3_0F12, 1'b1, 1'b0, 1'b0, e + 1);
    drain();
    chk("busy_after_commit", 32'(busy), 32'h0);

    // Three bad frames from a fresh reset -> lockout
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_start(1'b1);
      send_bits({8'h7A, 32'hA5C3_0F12}, 0, 40, 1'b0, e);
      push(32'h0, 1'b0, 1'b1, (k == 2), e + 1);
      drain();
      chk("busy_after_bad", 32'(busy), 32'h0);
    end
    chk("locked_after_3", 32'(locked_out), 32'h1);
    send_start(1'b0);
    send_bits({8'h7B, 32'hA5C3_0F12}, 0, 40, 1'b0, e);
    repeat (4) tick();
    chk("lock_key", key_out, 32'h0);
    chk("lock_ready", 32'(key_ready), 32'h0);
    chk("lock_held", 32'(locked_out), 32'h1);
    do_reset();
    check_reset_vals("unlock");

    // Commit then reload with gaps; old key must hold until the new commit
    send_start(1'b1);
    send_bits({8'h7B, 32'hA5C3_0F12}, 0, 40, 1'b0, e);
    push(32'hA5C3_0F12, 1'b1, 1'b0, 1'b0, e + 1);
    drain();
    send_start(1'b1);
    send_bits({8'h08, 32'h1234_5678}, 0, 20, 1'b1, e);
    chk("reload_key_hold", key_out, 32'hA5C3_0F12);
    chk("reload_ready_hold", 32'(key_ready), 32'h1);
    send_bits({8'h08, 32'h1234_5678}, 20, 40, 1'b1, e);
    push(32'h1234_5678, 1'b1, 1'b0, 1'b0, e + 1);
    drain();

    // Bad frame while a key is committed: err pulse, key kept
    send_start(1'b1);
    send_bits({8'h7A, 32'hA5C3_0F12}, 0, 40, 1'b0, e);
    push(32'h1234_5678, 1'b1, 1'b1, 1'b0, e + 1);
    drain();
    chk("bad_in_done_busy", 32'(busy), 32'h0);

    // Reset asserted while bit 20 is presented
    send_start(1'b1);
    send_bits({8'h7B, 32'hA5C3_0F12}, 0, 20, 1'b0, e);
    sdi = 1'b1; sdi_valid = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; sdi_valid = 1'b0;
    check_reset_vals("midframe_reset");

    // Restart after 17 garbage bits, then a full good frame
    send_start(1'b1);
    send_bits({8'hFF, 32'hFFFF_FFFF}, 0, 17, 1'b0, e);
    send_start(1'b1);
    send_bits({8'h7B, 32'hA5C3_0F12}, 0, 40, 1'b0, e);
    push(32'hA5C3_0F12, 1'b1, 1'b0, 1'b0, e + 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
